// File: rtl/dmem_wbuf.sv
// Data-memory write buffer: posts CPU stores into a FIFO, forwards loads from it,
// and drains to a handshaked memory one transaction at a time.
module dmem_wbuf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic        cpu_w,
  input  logic        cpu_r,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StRdone} state_e;

  state_e             state_q, state_d;
  logic [29:0]        ent_addr_q [DEPTH];
  logic [31:0]        ent_data_q [DEPTH];
  logic [DEPTH-1:0]   ent_valid_q;
  logic [PtrW-1:0]    head_q, tail_q;
  logic [CntW-1:0]    count_q;
  logic [31:0]        rd_q;
  logic [29:0]        rd_addr_q;

  logic            full, enq, deq, load, hit, miss;
  logic [31:0]     hit_data;
  logic [PtrW-1:0] idx;

  assign full = (count_q == CntW'(DEPTH));
  assign load = cpu_r && !cpu_w;
  assign enq  = rst && cpu_w && !full;
  assign deq  = (state_q == StWrite) && mem_ack;
  assign miss = load && !hit;

  // Scan oldest to youngest so the last match (youngest store) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    idx      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head_q + PtrW'(i);
      if (CntW'(i) < count_q && ent_valid_q[idx] && ent_addr_q[idx] == cpu_addr[31:2]) begin
        hit      = 1'b1;
        hit_data = ent_data_q[idx];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (miss)                state_d = StRead;
        else if (count_q != '0)  state_d = StWrite;
      end
      StWrite: if (mem_ack) state_d = StIdle;
      StRead:  if (mem_ack) state_d = StRdone;
      StRdone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    cpu_stall = 1'b0;
    cpu_rdata = '0;
    if (rst) begin
      if (state_q == StWrite) begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {ent_addr_q[head_q], 2'b00};
        mem_wdata = ent_data_q[head_q];
      end else if (state_q == StRead) begin
        mem_req  = 1'b1;
        mem_addr = {rd_addr_q, 2'b00};
      end
      // Stall uses registered count only: no mem_ack -> cpu_stall path.
      if (cpu_w) begin
        cpu_stall = full;
      end else if (cpu_r) begin
        cpu_stall = (state_q != StRdone) && !hit;
        if (state_q == StRdone) cpu_rdata = rd_q;
        else if (hit)           cpu_rdata = hit_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      ent_valid_q <= '0;
      rd_q        <= '0;
      rd_addr_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_q + CntW'(enq) - CntW'(deq);
      if (deq) begin
        ent_valid_q[head_q] <= 1'b0;
        head_q              <= head_q + PtrW'(1);
      end
      if (enq) begin
        ent_valid_q[tail_q] <= 1'b1;
        tail_q              <= tail_q + PtrW'(1);
      end
      if (state_q == StIdle && miss) rd_addr_q <= cpu_addr[31:2];
      if (state_q == StRead && mem_ack) rd_q <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      ent_addr_q[tail_q] <= cpu_addr[31:2];
      ent_data_q[tail_q] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_wbuf.sv
// Directed self-checking bench for dmem_wbuf: reset, post/drain, full, forwarding,
// load miss and reset during a read.
module tb_dmem_wbuf;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        cpu_w, cpu_r, cpu_stall, mem_req, mem_we, mem_ack;

  int tests = 0;
  int fails = 0;

  dmem_wbuf #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_w(cpu_w), .cpu_r(cpu_r),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; cpu_w = 1'b1; cpu_r = 1'b0; cpu_addr = 32'h40; cpu_wdata = 32'h55;
    mem_ack = 1'b1; mem_rdata = 32'h0;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if ({cpu_stall, mem_req, mem_we} !== 3'b000 || cpu_rdata !== 32'h0 ||
          mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
        fails++;
        $display("FAIL reset_outputs cyc%0d got stall=%b req=%b we=%b rd=%h a=%h wd=%h want all 0",
                 k, cpu_stall, mem_req, mem_we, cpu_rdata, mem_addr, mem_wdata);
      end
      step();
    end
    rst = 1'b1; cpu_w = 1'b0; mem_ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
        fails++;
        $display("FAIL reset_release cyc%0d got stall=%b req=%b want 0 0", k, cpu_stall, mem_req);
      end
      step();
    end
  endtask

  task automatic test_post_drain();
    bit          exp_req [9];
    logic [31:0] exp_a [9];
    logic [31:0] exp_d [9];
    exp_req = '{0, 0, 1, 0, 1, 0, 1, 0, 0};
    exp_a   = '{0, 0, 32'h100, 0, 32'h104, 0, 32'h108, 0, 0};
    exp_d   = '{0, 0, 32'h1111, 0, 32'h2222, 0, 32'h3333, 0, 0};
    mem_ack = 1'b1;
    for (int c = 0; c < 9; c++) begin
      cpu_w     = (c < 3);
      cpu_addr  = 32'h100 + 32'(4 * c);
      cpu_wdata = 32'h1111 * 32'(c + 1);
      #1;
      tests++;
      if (cpu_stall !== 1'b0 || mem_req !== exp_req[c] || mem_we !== exp_req[c] ||
          mem_addr !== exp_a[c] || mem_wdata !== exp_d[c]) begin
        fails++;
        $display("FAIL post_drain cyc%0d got stall=%b req=%b we=%b a=%h d=%h want 0 %b %b %h %h",
                 c, cpu_stall, mem_req, mem_we, mem_addr, mem_wdata,
                 exp_req[c], exp_req[c], exp_a[c], exp_d[c]);
      end
      step();
    end
    cpu_w = 1'b0;
  endtask

  task automatic test_full();
    mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cpu_w = 1'b1; cpu_addr = 32'h10 + 32'(4 * i); cpu_wdata = 32'(i + 1);
      #1;
      tests++;
      if (cpu_stall !== 1'b0) begin
        fails++;
        $display("FAIL full_store%0d stall got %b want 0", i, cpu_stall);
      end
      step();
    end
    cpu_addr = 32'h20; cpu_wdata = 32'h5;
    for (int k = 0; k < 2; k++) begin
      #1;
      tests++;
      if (cpu_stall !== 1'b1 || mem_req !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'h1) begin
        fails++;
        $display("FAIL full_stall cyc%0d got stall=%b req=%b a=%h d=%h want 1 1 00000010 00000001",
                 k, cpu_stall, mem_req, mem_addr, mem_wdata);
      end
      step();
    end
    mem_ack = 1'b1;
    #1;
    tests++;
    if (cpu_stall !== 1'b1) begin
      fails++;
      $display("FAIL full_ack_cycle stall got %b want 1", cpu_stall);
    end
    step();
    mem_ack = 1'b0;
    #1;
    tests++;
    if (cpu_stall !== 1'b0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL full_release got stall=%b req=%b want 0 0", cpu_stall, mem_req);
    end
    step();
    cpu_w = 1'b0; mem_ack = 1'b1;
    for (int j = 0; j < 9; j++) begin
      logic        er;
      logic [31:0] ea, ed;
      er = (j % 2 == 0) && (j < 8);
      ea = er ? 32'h14 + 32'(4 * (j / 2)) : 32'h0;
      ed = er ? 32'(2 + j / 2) : 32'h0;
      #1;
      tests++;
      if (mem_req !== er || mem_addr !== ea || mem_wdata !== ed) begin
        fails++;
        $display("FAIL full_drain cyc%0d got req=%b a=%h d=%h want %b %h %h",
                 j, mem_req, mem_addr, mem_wdata, er, ea, ed);
      end
      step();
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_forward();
    mem_ack = 1'b0; cpu_r = 1'b0;
    cpu_w = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hAAAA;
    step();
    cpu_wdata = 32'hBBBB;
    step();
    cpu_w = 1'b0; cpu_r = 1'b1; cpu_addr = 32'h202;
    #1;
    tests++;
    if (cpu_rdata !== 32'hBBBB || cpu_stall !== 1'b0 || mem_we !== 1'b1 ||
        mem_addr !== 32'h200 || mem_wdata !== 32'hAAAA) begin
      fails++;
      $display("FAIL fwd_youngest got rd=%h stall=%b we=%b a=%h d=%h want BBBB 0 1 200 AAAA",
               cpu_rdata, cpu_stall, mem_we, mem_addr, mem_wdata);
    end
    step();
    cpu_w = 1'b1; cpu_addr = 32'h204; cpu_wdata = 32'hCCCC;
    #1;
    tests++;
    if (cpu_rdata !== 32'h0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL fwd_conflict got rd=%h stall=%b want 0 0", cpu_rdata, cpu_stall);
    end
    step();
    cpu_w = 1'b0;
    #1;
    tests++;
    if (cpu_rdata !== 32'hCCCC || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL fwd_conflict_store got rd=%h stall=%b want CCCC 0", cpu_rdata, cpu_stall);
    end
    step();
    cpu_r = 1'b0; mem_ack = 1'b1;
    repeat (8) step();
    mem_ack = 1'b0;
    tests++;
    if (mem_req !== 1'b0) begin
      fails++;
      $display("FAIL fwd_drained req got %b want 0", mem_req);
    end
  endtask

  task automatic test_load_miss();
    mem_ack = 1'b0; mem_rdata = 32'hDEAD;
    cpu_w = 1'b0; cpu_r = 1'b1; cpu_addr = 32'h300;
    #1;
    tests++;
    if (cpu_stall !== 1'b1 || mem_req !== 1'b0 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL miss_first got stall=%b req=%b rd=%h want 1 0 0", cpu_stall, mem_req, cpu_rdata);
    end
    step();
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        mem_ack = 1'b1; mem_rdata = 32'hCAFE;
      end
      #1;
      tests++;
      if (cpu_stall !== 1'b1 || mem_req !== 1'b1 || mem_we !== 1'b0 ||
          mem_addr !== 32'h300 || cpu_rdata !== 32'h0) begin
        fails++;
        $display("FAIL miss_read cyc%0d got stall=%b req=%b we=%b a=%h rd=%h want 1 1 0 300 0",
                 k, cpu_stall, mem_req, mem_we, mem_addr, cpu_rdata);
      end
      step();
    end
    mem_ack = 1'b0; mem_rdata = 32'hDEAD;
    #1;
    tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'hCAFE || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL miss_rdone got stall=%b rd=%h req=%b want 0 CAFE 0", cpu_stall, cpu_rdata, mem_req);
    end
    step();
    cpu_r = 1'b0;
    #1;
    tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h0 || mem_req !== 1'b0) begin
      fails++;
      $display("FAIL miss_after got stall=%b rd=%h req=%b want 0 0 0", cpu_stall, cpu_rdata, mem_req);
    end
    step();
  endtask

  task automatic test_reset_mid_read();
    mem_ack = 1'b0; cpu_r = 1'b0;
    cpu_w = 1'b1; cpu_addr = 32'h400; cpu_wdata = 32'h44;
    step();
    cpu_w = 1'b0; cpu_r = 1'b1; cpu_addr = 32'h500;
    step();
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h500) begin
      fails++;
      $display("FAIL rmr_read_first got req=%b we=%b a=%h want 1 0 500", mem_req, mem_we, mem_addr);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL rmr_in_reset got req=%b stall=%b want 0 0", mem_req, cpu_stall);
    end
    step();
    rst = 1'b1; cpu_r = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      tests++;
      if (mem_req !== 1'b0 || cpu_stall !== 1'b0) begin
        fails++;
        $display("FAIL rmr_after cyc%0d got req=%b stall=%b want 0 0", k, mem_req, cpu_stall);
      end
      step();
    end
    cpu_r = 1'b1; cpu_addr = 32'h400;
    #1;
    tests++;
    if (cpu_stall !== 1'b1 || cpu_rdata !== 32'h0) begin
      fails++;
      $display("FAIL rmr_abandoned got stall=%b rd=%h want 1 0", cpu_stall, cpu_rdata);
    end
    step();
    #1;
    tests++;
    if (mem_req !== 1'b1 || mem_addr !== 32'h400) begin
      fails++;
      $display("FAIL rmr_reread got req=%b a=%h want 1 400", mem_req, mem_addr);
    end
    mem_ack = 1'b1; mem_rdata = 32'h77;
    step();
    mem_ack = 1'b0; mem_rdata = 32'h0;
    #1;
    tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h77) begin
      fails++;
      $display("FAIL rmr_reread_data got stall=%b rd=%h want 0 77", cpu_stall, cpu_rdata);
    end
    step();
    cpu_r = 1'b0; cpu_w = 1'b1; cpu_addr = 32'h600; cpu_wdata = 32'h66;
    #1;
    tests++;
    if (cpu_stall !== 1'b0) begin
      fails++;
      $display("FAIL rmr_store stall got %b want 0", cpu_stall);
    end
    step();
    cpu_w = 1'b0; cpu_r = 1'b1;
    #1;
    tests++;
    if (cpu_stall !== 1'b0 || cpu_rdata !== 32'h66) begin
      fails++;
      $display("FAIL rmr_hit got stall=%b rd=%h want 0 66", cpu_stall, cpu_rdata);
    end
    step();
    cpu_r = 1'b0;
  endtask

  initial begin
    test_reset();
    test_post_drain();
    test_full();
    test_forward();
    test_load_miss();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
